// File: rtl/motor_pwm_multi_pkg.sv
// Shared channel state type, direction encoding and default timing constants
// for the multi-channel H-bridge PWM driver.
package motor_pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DEAD,
        ST_FAULT
    } chan_state_e;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    localparam int DEF_PERIOD   = 250000;
    localparam int DEF_DEAD_CYC = 1000;
    localparam int DEF_OC_LIMIT = 250000;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/motor_pwm_multi_chan.sv
// One H-bridge channel: IDLE/RUN/DEAD/FAULT FSM, duty register, dead-time and
// overcurrent counters. Soft duty ramp is built when SOFT_RAMP_EN is defined.
module motor_pwm_chan
    import motor_pwm_pkg::*;
#(
    parameter int CNT_W     = 19,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int DEAD_CYC  = DEF_DEAD_CYC,
    parameter int OC_LIMIT  = DEF_OC_LIMIT,
    parameter int OC_W      = 21,
    parameter int RAMP_STEP = 6250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             wrap_i,
    input  logic [CNT_W-1:0] duty_cmd_i,
    input  logic             dir_cmd_i,
    input  logic             en_cmd_i,
    input  logic             oc_sense_i,
    input  logic             fault_clr_i,
    output logic             pwm_o,
    output logic             in_a_o,
    output logic             in_b_o,
    output logic             fault_o,
    output logic             dir_state_o
);

    localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
`ifdef SOFT_RAMP_EN
    localparam int STEP = RAMP_STEP;
`else
    // A step no smaller than a full period always lands on the target at once.
    localparam int STEP = max_i(RAMP_STEP, PERIOD);
`endif
    localparam logic [CNT_W-1:0] PERIOD_V  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] STEP_V    = CNT_W'(STEP);
    localparam logic [OC_W-1:0]  OC_TRIP   = OC_W'(OC_LIMIT - 1);
    localparam logic [DW-1:0]    DEAD_LAST = DW'(DEAD_CYC - 1);

    chan_state_e      state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [OC_W-1:0]  oc_q, oc_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic             pwm_q, pwm_d;
    logic [CNT_W-1:0] tgt, diff, move, ramped;
    logic             oc_trip;

    always_comb begin
        tgt    = (duty_cmd_i > PERIOD_V) ? PERIOD_V : duty_cmd_i;
        diff   = (tgt > duty_q) ? (tgt - duty_q) : (duty_q - tgt);
        move   = (diff > STEP_V) ? STEP_V : diff;
        ramped = (tgt > duty_q) ? (duty_q + move) : (duty_q - move);
    end

    always_comb begin
        if (!oc_sense_i)
            oc_d = '0;
        else if (oc_q != '1)
            oc_d = oc_q + OC_W'(1);
        else
            oc_d = oc_q;
        oc_trip = oc_sense_i && (oc_q >= OC_TRIP);
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        if (oc_trip) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_cmd_i) begin
                        state_d = ST_RUN;
                        dir_d   = dir_cmd_i;
                    end
                end
                ST_RUN: begin
                    if (!en_cmd_i) begin
                        state_d = ST_IDLE;
                    end else if (dir_cmd_i != dir_q) begin
                        state_d = ST_DEAD;
                        dead_d  = '0;
                    end
                end
                ST_DEAD: begin
                    if (!en_cmd_i) begin
                        state_d = ST_IDLE;
                    end else if (dead_q == DEAD_LAST) begin
                        state_d = ST_RUN;
                        dir_d   = dir_cmd_i;
                    end else begin
                        dead_d = dead_q + DW'(1);
                    end
                end
                ST_FAULT: begin
                    if (fault_clr_i && !oc_sense_i)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // Duty is held at zero outside RUN, so every RUN entry ramps from zero.
        duty_d = (state_d != ST_RUN) ? '0 : (wrap_i ? ramped : duty_q);
        pwm_d  = (state_d == ST_RUN) && (cnt_i < duty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_FWD;
            duty_q  <= '0;
            oc_q    <= '0;
            dead_q  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            duty_q  <= duty_d;
            oc_q    <= oc_d;
            dead_q  <= dead_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o       = pwm_q;
    assign in_a_o      = (state_q == ST_RUN) && (dir_q == DIR_FWD);
    assign in_b_o      = (state_q == ST_RUN) && (dir_q == DIR_REV);
    assign fault_o     = (state_q == ST_FAULT);
    assign dir_state_o = dir_q;

endmodule

// File: rtl/motor_pwm_multi.sv
// N-channel H-bridge PWM controller: shared carrier counter plus one
// motor_pwm_chan per channel. Optional soft ramp: define SOFT_RAMP_EN.
module motor_pwm_multi
    import motor_pwm_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 19,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int DEAD_CYC  = DEF_DEAD_CYC,
    parameter int OC_LIMIT  = DEF_OC_LIMIT,
    parameter int OC_W      = 21,
    parameter int RAMP_STEP = 6250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*CNT_W-1:0] duty_cmd,
    input  logic [N_CH-1:0]       dir_cmd,
    input  logic [N_CH-1:0]       en_cmd,
    input  logic [N_CH-1:0]       oc_sense,
    input  logic                  fault_clr,
    output logic [N_CH-1:0]       pwm_out,
    output logic [N_CH-1:0]       in_a,
    output logic [N_CH-1:0]       in_b,
    output logic [N_CH-1:0]       fault,
    output logic [N_CH-1:0]       dir_state,
    output logic                  period_start
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;
    logic             ps_q;

    assign wrap  = (cnt_q == LAST);
    assign cnt_d = wrap ? '0 : (cnt_q + CNT_W'(1));

    // Registered from the wrap so it is low straight out of reset and
    // otherwise high exactly while the counter reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ps_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ps_q  <= wrap;
        end
    end

    assign period_start = ps_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        motor_pwm_chan #(
            .CNT_W     (CNT_W),
            .PERIOD    (PERIOD),
            .DEAD_CYC  (DEAD_CYC),
            .OC_LIMIT  (OC_LIMIT),
            .OC_W      (OC_W),
            .RAMP_STEP (RAMP_STEP)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .cnt_i       (cnt_q),
            .wrap_i      (wrap),
            .duty_cmd_i  (duty_cmd[i*CNT_W +: CNT_W]),
            .dir_cmd_i   (dir_cmd[i]),
            .en_cmd_i    (en_cmd[i]),
            .oc_sense_i  (oc_sense[i]),
            .fault_clr_i (fault_clr),
            .pwm_o       (pwm_out[i]),
            .in_a_o      (in_a[i]),
            .in_b_o      (in_b[i]),
            .fault_o     (fault[i]),
            .dir_state_o (dir_state[i])
        );
    end

endmodule

// File: tb/tb_motor_pwm_multi.sv
// Bench for motor_pwm_multi: directed scenarios plus randomized stimulus,
// every cycle compared against a behavioural channel model.
module tb_motor_pwm_multi;

    localparam int N   = 2;
    localparam int CW  = 19;
    localparam int P   = 100;
    localparam int DC  = 5;
    localparam int OCL = 8;
    localparam int RS  = 25;
`ifdef SOFT_RAMP_EN
    localparam int STEP = RS;
`else
    localparam int STEP = P;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N*CW-1:0] duty_cmd;
    logic [N-1:0]    dir_cmd, en_cmd, oc_sense;
    logic            fault_clr;
    logic [N-1:0]    pwm_out, in_a, in_b, fault, dir_state;
    logic            period_start;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    motor_pwm_multi #(
        .N_CH      (N),
        .CNT_W     (CW),
        .PERIOD    (P),
        .DEAD_CYC  (DC),
        .OC_LIMIT  (OCL),
        .OC_W      (21),
        .RAMP_STEP (RS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .duty_cmd     (duty_cmd),
        .dir_cmd      (dir_cmd),
        .en_cmd       (en_cmd),
        .oc_sense     (oc_sense),
        .fault_clr    (fault_clr),
        .pwm_out      (pwm_out),
        .in_a         (in_a),
        .in_b         (in_b),
        .fault        (fault),
        .dir_state    (dir_state),
        .period_start (period_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: running/dead-time-left/faulted per channel.
    int m_cnt = 0;
    bit m_ps  = 1'b0;
    int m_duty[N];
    int m_streak[N];
    int m_dead[N];
    bit m_run[N];
    bit m_flt[N];
    bit m_dir[N];
    bit m_pwm[N];

    task automatic model_step();
        bit wrap;
        if (rst) begin
            m_cnt = 0;
            m_ps  = 1'b0;
            for (int c = 0; c < N; c++) begin
                m_duty[c] = 0; m_streak[c] = 0; m_dead[c] = 0;
                m_run[c] = 1'b0; m_flt[c] = 1'b0; m_dir[c] = 1'b1; m_pwm[c] = 1'b0;
            end
            return;
        end
        wrap = (m_cnt == P - 1);
        for (int c = 0; c < N; c++) begin
            int streak, tgt, gap;
            streak = oc_sense[c] ? m_streak[c] + 1 : 0;
            if (oc_sense[c] && streak >= OCL) begin
                m_flt[c] = 1'b1; m_run[c] = 1'b0; m_dead[c] = 0;
            end else if (m_flt[c]) begin
                if (fault_clr && !oc_sense[c]) m_flt[c] = 1'b0;
            end else if (m_run[c]) begin
                if (!en_cmd[c]) m_run[c] = 1'b0;
                else if (dir_cmd[c] != m_dir[c]) begin
                    m_run[c] = 1'b0; m_dead[c] = DC;
                end
            end else if (m_dead[c] > 0) begin
                if (!en_cmd[c]) m_dead[c] = 0;
                else if (m_dead[c] == 1) begin
                    m_dead[c] = 0; m_run[c] = 1'b1; m_dir[c] = dir_cmd[c];
                end else m_dead[c]--;
            end else if (en_cmd[c]) begin
                m_run[c] = 1'b1; m_dir[c] = dir_cmd[c];
            end
            m_pwm[c] = m_run[c] && (m_cnt < m_duty[c]);
            if (!m_run[c]) m_duty[c] = 0;
            else if (wrap) begin
                tgt = int'(duty_cmd[c*CW +: CW]);
                if (tgt > P) tgt = P;
                gap = (tgt > m_duty[c]) ? tgt - m_duty[c] : m_duty[c] - tgt;
                if (gap > STEP) gap = STEP;
                m_duty[c] = (tgt > m_duty[c]) ? m_duty[c] + gap : m_duty[c] - gap;
            end
            m_streak[c] = streak;
        end
        m_ps  = wrap;
        m_cnt = wrap ? 0 : m_cnt + 1;
    endtask

    function automatic logic [5*N:0] model_bits();
        logic [N-1:0] p, a, b, f, d;
        for (int c = 0; c < N; c++) begin
            p[c] = m_pwm[c];
            a[c] = m_run[c] && m_dir[c];
            b[c] = m_run[c] && !m_dir[c];
            f[c] = m_flt[c];
            d[c] = m_dir[c];
        end
        return {p, a, b, f, d, m_ps};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cycle", 32'({pwm_out, in_a, in_b, fault, dir_state, period_start}), 32'(model_bits()));
    endtask

    task automatic set_duty(input int ch, input int val);
        duty_cmd[ch*CW +: CW] = CW'(val);
    endtask

    task automatic wait_ps();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!period_start && k < 2 * P);
        check("ps_seen", 32'(period_start), 32'd1);
    endtask

    // Call at a period_start cycle; counts pwm highs over the following period.
    task automatic window(input int ch, input int change_at, input int newval, output int hi);
        hi = 0;
        for (int j = 1; j <= P; j++) begin
            tick();
            hi += int'(pwm_out[ch]);
            if (j == change_at) set_duty(ch, newval);
        end
    endtask

    initial begin
        int hi, k;
        rst = 1'b1; duty_cmd = '0; dir_cmd = '1; en_cmd = '0; oc_sense = '0; fault_clr = 1'b0;
        tick(); tick();
        check("rst_outs", 32'({pwm_out, in_a, in_b, fault, period_start}), 32'd0);
        check("rst_dir", 32'(dir_state), 32'(2'b11));

        rst = 1'b0; en_cmd[0] = 1'b1; set_duty(0, 0);
        wait_ps();
`ifndef SOFT_RAMP_EN
        window(0, 50, 25, hi);  check("duty0", 32'(hi), 32'd0);
        window(0, 50, 100, hi); check("duty25", 32'(hi), 32'd25);
        window(0, 50, 150, hi); check("duty100", 32'(hi), 32'd100);
        window(0, -1, 0, hi);   check("duty150", 32'(hi), 32'd100);
`else
        set_duty(0, 100);
        window(0, -1, 0, hi);   check("ramp0", 32'(hi), 32'd0);
        window(0, -1, 0, hi);   check("ramp25", 32'(hi), 32'd25);
        window(0, -1, 0, hi);   check("ramp50", 32'(hi), 32'd50);
        window(0, -1, 0, hi);   check("ramp75", 32'(hi), 32'd75);
        window(0, 50, 60, hi);  check("ramp100", 32'(hi), 32'd100);
        window(0, -1, 0, hi);   check("ramp_dn75", 32'(hi), 32'd75);
        window(0, -1, 0, hi);   check("ramp_dn60", 32'(hi), 32'd60);
`endif
        check("fwd_bridge", 32'({in_a[0], in_b[0]}), 32'(2'b10));

        set_duty(0, 50);
        for (int w = 0; w < 3; w++) window(0, -1, 0, hi);
        check("d50", 32'(hi), 32'd50);
        repeat (10) tick();
        check("rev_pre_pwm", 32'(pwm_out[0]), 32'd1);
        dir_cmd[0] = 1'b0;
        tick();
        k = 0;
        while (!in_a[0] && !in_b[0] && !pwm_out[0] && k < 20) begin
            k++;
            tick();
        end
        check("dead_len", 32'(k), 32'(DC));
        check("rev_bridge", 32'({in_a[0], in_b[0]}), 32'(2'b01));
        check("rev_dir", 32'(dir_state[0]), 32'd0);

        en_cmd[1] = 1'b1; set_duty(1, 75);
        wait_ps();
        for (int w = 0; w < 4; w++) window(1, -1, 0, hi);
        check("ch1_base", 32'(hi), 32'd75);

        oc_sense[0] = 1'b1;
        repeat (7) tick();
        oc_sense[0] = 1'b0;
        tick();
        check("oc7_nofault", 32'(fault[0]), 32'd0);
        oc_sense[0] = 1'b1;
        repeat (7) tick();
        check("oc_pre", 32'(fault[0]), 32'd0);
        tick();
        check("oc8_fault", 32'(fault[0]), 32'd1);
        check("oc8_pwm", 32'(pwm_out[0]), 32'd0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clr_blocked", 32'(fault[0]), 32'd1);
        wait_ps();
        window(1, -1, 0, hi);
        check("ch1_indep", 32'(hi), 32'd75);
        check("ch0_held", 32'(fault[0]), 32'd1);
        oc_sense[0] = 1'b0; fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clr_ok", 32'({fault[0], in_a[0], in_b[0]}), 32'd0);

        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rrst_outs", 32'({pwm_out, in_a, in_b, fault, period_start}), 32'd0);
        check("rrst_dir", 32'(dir_state), 32'(2'b11));
        k = 0;
        do begin
            tick();
            k++;
        end while (!period_start && k < 2 * P);
        check("rrst_cnt", 32'(k), 32'(P));

        dir_cmd[0] = 1'b1;
        tick(); tick();
        check("dead_bridge", 32'({in_a[0], in_b[0]}), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("drst_outs", 32'({pwm_out, in_a, in_b, fault, period_start}), 32'd0);

        for (int t = 0; t < 3000; t++) begin
            rst = ($urandom_range(0, 499) == 0);
            fault_clr = ($urandom_range(0, 29) == 0);
            for (int c = 0; c < N; c++) begin
                en_cmd[c] = ($urandom_range(0, 99) != 0);
                if ($urandom_range(0, 199) == 0) dir_cmd[c] = ~dir_cmd[c];
                if (oc_sense[c]) oc_sense[c] = ($urandom_range(0, 99) < 85);
                else oc_sense[c] = ($urandom_range(0, 99) < 2);
                if ($urandom_range(0, 149) == 0) set_duty(c, int'($urandom_range(0, 160)));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
